// File: rtl/slu_pkg.sv
// Shared types for the serial logic unit: FSM states, function and routing codes.
package slu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10,
    HOLD  = 2'b11
  } fsm_state_t;

  typedef enum logic [2:0] {
    FnAnd  = 3'b000,
    FnOr   = 3'b001,
    FnXor  = 3'b010,
    FnOne  = 3'b011,
    FnNand = 3'b100,
    FnNor  = 3'b101,
    FnXnor = 3'b110,
    FnZero = 3'b111
  } logic_fn_t;

  // Which MSB inputs receive the function result.
  typedef enum logic [1:0] {
    RtKeep = 2'b00,  // (a, b): plain rotate
    RtFToB = 2'b01,  // (a, f)
    RtFToA = 2'b10,  // (f, b)
    RtSwap = 2'b11   // (b, a)
  } route_t;

  function automatic logic apply_fn(input logic_fn_t fn, input logic a, input logic b);
    logic res;
    unique case (fn)
      FnAnd:   res = a & b;
      FnOr:    res = a | b;
      FnXor:   res = a ^ b;
      FnOne:   res = 1'b1;
      FnNand:  res = ~(a & b);
      FnNor:   res = ~(a | b);
      FnXnor:  res = ~(a ^ b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/slu_bit_alu.sv
// One-bit logic function plus MSB routing for the serial logic unit.
module slu_bit_alu
  import slu_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic_fn_t F,
  input  route_t    R,
  output logic      f,
  output logic      newA,
  output logic      newB
);

  // Evaluate the function and pick what feeds each register's MSB.
  always_comb begin
    f    = apply_fn(F, a, b);
    newA = a;
    newB = b;
    unique case (R)
      RtKeep: begin
        newA = a;
        newB = b;
      end
      RtFToB: begin
        newA = a;
        newB = f;
      end
      RtFToA: begin
        newA = f;
        newB = b;
      end
      default: begin
        newA = b;
        newB = a;
      end
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial A/B logic processor with pass count, busy/done handshake and auto-repeat.
module serial_logic_unit
  import slu_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned PASS_W = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LoadA,
  input  logic              LoadB,
  input  logic              Execute,
  input  logic              Repeat,
  input  logic [PASS_W-1:0] Passes,
  input  logic [2:0]        F,
  input  logic [1:0]        R,
  input  logic [W-1:0]      Din,
  output logic [W-1:0]      A,
  output logic [W-1:0]      B,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        State
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] BitLast = CntW'(W - 1);

  fsm_state_t        state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [CntW-1:0]   bit_q, bit_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic_fn_t         fn_q, fn_d;
  route_t            rt_q, rt_d;

  logic f_bit;
  logic new_a;
  logic new_b;

  slu_bit_alu u_alu (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .F    (fn_q),
    .R    (rt_q),
    .f    (f_bit),
    .newA (new_a),
    .newB (new_b)
  );

  // Next-state logic: loads in IDLE, one shift per SHIFT cycle, rearm from HOLD.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    bit_d    = bit_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    fn_d     = fn_q;
    rt_d     = rt_q;

    unique case (state_q)
      IDLE: begin
        if (Execute) begin
          // Start wins over any load requested in the same cycle.
          fn_d     = logic_fn_t'(F);
          rt_d     = route_t'(R);
          passes_d = Passes;
          bit_d    = '0;
          pass_d   = '0;
          state_d  = SHIFT;
        end else begin
          if (LoadA) a_d = Din;
          if (LoadB) b_d = Din;
        end
      end
      SHIFT: begin
        a_d = {new_a, a_q[W-1:1]};
        b_d = {new_b, b_q[W-1:1]};
        if (bit_q == BitLast) begin
          bit_d = '0;
          // Compare before incrementing so the pass counter never wraps.
          if (pass_q == passes_q) begin
            pass_d  = '0;
            state_d = DONE;
          end else begin
            pass_d = pass_q + PASS_W'(1);
          end
        end else begin
          bit_d = bit_q + CntW'(1);
        end
      end
      DONE: begin
        state_d = HOLD;
      end
      default: begin
        if (!Execute) begin
          state_d = IDLE;
        end else if (Repeat) begin
          fn_d     = logic_fn_t'(F);
          rt_d     = route_t'(R);
          passes_d = Passes;
          bit_d    = '0;
          pass_d   = '0;
          state_d  = SHIFT;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      bit_q    <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      fn_q     <= FnAnd;
      rt_q     <= RtKeep;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bit_q    <= bit_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      fn_q     <= fn_d;
      rt_q     <= rt_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign Busy  = (state_q == SHIFT);
  assign Done  = (state_q == DONE);
  assign State = state_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Scoreboard bench for serial_logic_unit at W=8, plus auto-repeat runs at W=4 and W=16.
module tb_serial_logic_unit;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_a, load_b;
  logic        exec8, exec4, exec16;
  logic        rep;
  logic [1:0]  passes;
  logic [2:0]  f;
  logic [1:0]  r;
  logic [15:0] din;

  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic [15:0] a16, b16;
  logic        busy8, busy4, busy16;
  logic        done8, done4, done16;
  logic [1:0]  st8, st4, st16;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int t;
  int d3;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q16[$];
  exp_t e8, e4, e16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_logic_unit #(.W(8), .PASS_W(2)) u8 (
    .Clk(clk), .Reset(reset), .LoadA(load_a), .LoadB(load_b), .Execute(exec8),
    .Repeat(rep), .Passes(passes), .F(f), .R(r), .Din(din[7:0]),
    .A(a8), .B(b8), .Busy(busy8), .Done(done8), .State(st8)
  );

  serial_logic_unit #(.W(4), .PASS_W(2)) u4 (
    .Clk(clk), .Reset(reset), .LoadA(load_a), .LoadB(load_b), .Execute(exec4),
    .Repeat(rep), .Passes(passes), .F(f), .R(r), .Din(din[3:0]),
    .A(a4), .B(b4), .Busy(busy4), .Done(done4), .State(st4)
  );

  serial_logic_unit #(.W(16), .PASS_W(2)) u16 (
    .Clk(clk), .Reset(reset), .LoadA(load_a), .LoadB(load_b), .Execute(exec16),
    .Repeat(rep), .Passes(passes), .F(f), .R(r), .Din(din),
    .A(a16), .B(b16), .Busy(busy16), .Done(done16), .State(st16)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: Done pulse with no expected result pending (cycle %0d)", nm, cyc);
  endtask

  // Monitors: pop the oldest expectation whenever a Done pulse is seen.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) unexpected("done8");
      else begin
        e8 = q8.pop_front();
        check("w8 done cycle", cyc, e8.cyc);
        check("w8 A at done", {24'd0, a8}, {16'd0, e8.a});
        check("w8 B at done", {24'd0, b8}, {16'd0, e8.b});
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) unexpected("done4");
      else begin
        e4 = q4.pop_front();
        check("w4 done cycle", cyc, e4.cyc);
        check("w4 A at done", {28'd0, a4}, {16'd0, e4.a});
        check("w4 B at done", {28'd0, b4}, {16'd0, e4.b});
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) unexpected("done16");
      else begin
        e16 = q16.pop_front();
        check("w16 done cycle", cyc, e16.cyc);
        check("w16 A at done", {16'd0, a16}, {16'd0, e16.a});
        check("w16 B at done", {16'd0, b16}, {16'd0, e16.b});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Loads are broadcast; only DUTs sitting in IDLE take them.
  task automatic load_ab(input logic [15:0] va, input logic [15:0] vb);
    din    = va;
    load_a = 1'b1;
    tick(1);
    load_a = 1'b0;
    din    = vb;
    load_b = 1'b1;
    tick(1);
    load_b = 1'b0;
    din    = '0;
  endtask

  task automatic push8(input int c, input logic [15:0] va, input logic [15:0] vb);
    exp_t e;
    e.cyc = c;
    e.a   = va;
    e.b   = vb;
    q8.push_back(e);
  endtask

  initial begin
    exp_t e;
    reset  = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    exec8  = 1'b0;
    exec4  = 1'b0;
    exec16 = 1'b0;
    rep    = 1'b0;
    passes = 2'd0;
    f      = 3'b000;
    r      = 2'b00;
    din    = '0;
    tick(2);
    check("reset A", {24'd0, a8}, 32'h0);
    check("reset B", {24'd0, b8}, 32'h0);
    check("reset Busy", {31'd0, busy8}, 32'h0);
    check("reset Done", {31'd0, done8}, 32'h0);
    check("reset State", {30'd0, st8}, 32'h0);
    reset = 1'b1;
    tick(1);

    // Reset in the middle of a shift sequence.
    load_ab(16'h00A5, 16'h003C);
    f = 3'b000;
    r = 2'b10;
    passes = 2'd0;
    exec8 = 1'b1;
    tick(1);
    exec8 = 1'b0;
    check("busy after start", {31'd0, busy8}, 32'h1);
    tick(2);
    check("A after 2 shifts", {24'd0, a8}, 32'h29);
    check("B after 2 shifts", {24'd0, b8}, 32'h0F);
    reset = 1'b0;
    tick(1);
    check("midop reset A", {24'd0, a8}, 32'h0);
    check("midop reset B", {24'd0, b8}, 32'h0);
    check("midop reset Busy", {31'd0, busy8}, 32'h0);
    check("midop reset State", {30'd0, st8}, 32'h0);
    reset = 1'b1;
    tick(1);

    // AND into A; a load attempt during Busy must be ignored.
    load_ab(16'h00A5, 16'h003C);
    f = 3'b000;
    r = 2'b10;
    passes = 2'd0;
    exec8 = 1'b1;
    t = cyc;
    push8(t + 9, 16'h24, 16'h3C);
    tick(1);
    exec8  = 1'b0;
    din    = 16'h00FF;
    load_a = 1'b1;
    tick(3);
    check("busy mid AND", {31'd0, busy8}, 32'h1);
    load_a = 1'b0;
    din    = '0;
    tick(10);

    // XOR into B with Execute held and Repeat=0; F/R changes after start are ignored.
    load_ab(16'h00A5, 16'h003C);
    f = 3'b010;
    r = 2'b01;
    rep = 1'b0;
    exec8 = 1'b1;
    t = cyc;
    push8(t + 9, 16'hA5, 16'h99);
    tick(1);
    f = 3'b111;
    r = 2'b00;
    tick(13);
    check("hold while Execute high", {30'd0, st8}, 32'h3);
    exec8 = 1'b0;
    tick(2);
    check("idle after release", {30'd0, st8}, 32'h0);

    // Swap routing, two passes then one pass.
    load_ab(16'h00F0, 16'h000F);
    f = 3'b000;
    r = 2'b11;
    passes = 2'd1;
    exec8 = 1'b1;
    t = cyc;
    push8(t + 17, 16'hF0, 16'h0F);
    tick(1);
    exec8 = 1'b0;
    tick(20);
    load_ab(16'h00F0, 16'h000F);
    passes = 2'd0;
    exec8 = 1'b1;
    t = cyc;
    push8(t + 9, 16'h0F, 16'hF0);
    tick(1);
    exec8 = 1'b0;
    tick(12);

    // Auto-repeat at W=8: Done every W+2 cycles, A all ones.
    load_ab(16'h0000, 16'h005A);
    f = 3'b011;
    r = 2'b10;
    passes = 2'd0;
    rep = 1'b1;
    exec8 = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) push8(t + 9 + 10 * k, 16'hFF, 16'h5A);
    d3 = t + 29;
    while (cyc < d3) tick(1);
    exec8 = 1'b0;
    tick(4);

    // Auto-repeat at W=4.
    load_ab(16'h0000, 16'h0000);
    exec4 = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cyc = t + 5 + 6 * k;
      e.a   = 16'h000F;
      e.b   = 16'h0000;
      q4.push_back(e);
    end
    d3 = t + 17;
    while (cyc < d3) tick(1);
    exec4 = 1'b0;
    tick(4);

    // Auto-repeat at W=16.
    load_ab(16'h0000, 16'h0000);
    exec16 = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cyc = t + 17 + 18 * k;
      e.a   = 16'hFFFF;
      e.b   = 16'h0000;
      q16.push_back(e);
    end
    d3 = t + 53;
    while (cyc < d3) tick(1);
    exec16 = 1'b0;
    rep = 1'b0;
    tick(6);

    check("w8 results outstanding", q8.size(), 32'd0);
    check("w4 results outstanding", q4.size(), 32'd0);
    check("w16 results outstanding", q16.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Parametrised, bit-serial logic processor core. Next generation of the lab's fixed-width A/B logic processor.
- Holds two W-bit registers A and B. On Execute, it shifts both right W times. Each cycle it applies a 3-bit logic function to the LSBs and routes the result bit back into the MSBs.
- Adds over the fixed-width version: Busy/Done handshake, a programmable pass count, and single-shot/auto-repeat modes.
- Sits between the board-level input synchronisers/hex displays and the switches. All inputs arrive already synchronised and active-high.

Parameters:
- W, 8, register width in bits (≥2).
- PASS_W, 2, width of the pass-count input. Up to 2^PASS_W passes per Execute.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-low reset.
- LoadA  in  1  load Din into A (level, sampled in IDLE only).
- LoadB  in  1  load Din into B (level, sampled in IDLE only).
- Execute  in  1  start request (level).
- Repeat  in  1  1 = auto-rearm while Execute held; 0 = single-shot.
- Passes  in  PASS_W  number of W-cycle passes minus 1 (0 → 1 pass).
- F  in  3  function select, sampled at start.
- R  in  2  routing select, sampled at start.
- Din  in  W  parallel load data.
- A  out  W  register A contents.
- B  out  W  register B contents.
- Busy  out  1  high while shifting.
- Done  out  1  single-cycle pulse after the final shift.
- State  out  2  FSM state encoding, for debug LEDs.

Behaviour:
- Reset (Reset==0 at posedge):
  - A=0, B=0, Busy=0, Done=0, FSM=IDLE, bit counter=0, pass counter=0.
  - Reset overrides everything, including mid-shift; the partial result is discarded.
- F encoding, with a = A[0], b = B[0]:
  - 000 a&b; 001 a|b; 010 a^b; 011 1.
  - 100 ~(a&b); 101 ~(a|b); 110 ~(a^b); 111 0.
  - Result bit is f.
- R routing, giving the MSB inputs (newA, newB):
  - 00 (a, b)
  - 01 (a, f)
  - 10 (f, b)
  - 11 (b, a)
- Shift step: A <= {newA, A[W-1:1]}; B <= {newB, B[W-1:1]}.
- FSM states:
  - IDLE (00):
    - LoadA → A<=Din; LoadB → B<=Din (both may load in the same cycle).
    - Execute=1 → latch F, R and Passes; clear counters; go to SHIFT. Execute takes priority over loads in that cycle; no load occurs.
  - SHIFT (01):
    - Busy=1. One shift per cycle.
    - Bit counter 0..W-1. Wrap to 0 and increment the pass counter when it reaches W-1.
    - After the shift with bit counter==W-1 and pass counter==Passes latched value: go to DONE.
    - Loads, and changes to F/R/Passes, are ignored in this state.
  - DONE (10):
    - Done=1 for exactly this cycle; Busy=0.
    - Next state is HOLD.
  - HOLD (11):
    - Wait for Execute==0, then go to IDLE.
    - If Repeat==1 and Execute still high: re-latch F/R/Passes and go to SHIFT. No release is needed.
- Latency: Execute asserted in cycle t → first shift at edge t+1 → Done high in cycle t+1+W·(Passes+1).
- Execute deasserted mid-SHIFT has no effect; the operation completes.
- Passes=0, W=2 is the minimum legal case; it takes 2 cycles of SHIFT.
- Counter widths: bit counter $clog2(W); pass counter PASS_W. No overflow is possible because the compare happens before increment.

Decomposition:
- Package slu_pkg holds:
  - enum fsm_state_t {IDLE, SHIFT, DONE, HOLD};
  - enum logic_fn_t for the 8 F codes;
  - enum route_t for the 4 R codes.
- One sub-module, slu_bit_alu: combinational function and router. Inputs a, b, F, R; outputs f, newA, newB.
- Registers and FSM stay in the top module.

Test Plan:
- Reset mid-operation: W=8, A=0xA5, B=0x3C, start SHIFT, pull Reset low on the 3rd shift → next cycle A=0, B=0, Busy=0, State=IDLE.
- AND, route 10: A=0xA5, B=0x3C, F=000, R=10, Passes=0, pulse Execute → Done after 8 shifts; A=0x24, B=0x3C.
- XOR, route 01: same operands, F=010, R=01 → A=0xA5, B=0x99.
- Swap, multi-pass: A=0xF0, B=0x0F, R=11, Passes=1 → 16 shifts; A=0xF0, B=0x0F (double swap). With Passes=0 → A=0x0F, B=0xF0.
- Loads ignored during Busy: LoadA=1, Din=0xFF while Busy → A is unaffected. Execute held with Repeat=0 → exactly one Done until Execute is released.
- Auto-repeat: Execute held, Repeat=1, F=011, R=10, A=0x00 → Done pulses every W+2 cycles; A=0xFF after the first pass. Also run the same case at W=4 and W=16 to check parametrisation.
